// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, stall/bubble/flush sequencing and
// registered forwarding selects for the 5-stage RV32I pipeline.
// Optional feature macro: HAZARD_FWD_EN (defined = EX forwarding, only
// load-use stalls; undefined = no forwarding, stall until producer in WB).
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       ex_redirect,
  input  logic       mem_busy,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       bubble_idex,
  output logic       flush_ifid,
  output logic       freeze,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t     state;
  // Tracking table: one entry per downstream stage
  logic       ex_valid, mem_valid, wb_valid;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_load, mem_load, wb_load;

  logic       ex_a, ex_b, mem_a, mem_b;
  logic       hazard, redirect, in_flush, kill;
  logic [1:0] sel_a, sel_b;
  logic       unused_state;

  // WB entry is kept for visibility only: the write-through regfile covers it
  assign unused_state = ^{mem_load, wb_valid, wb_rd, wb_load, ex_load};

  // Hazard detection, forwarding choice and priority-resolved pipeline controls
  always_comb begin
    ex_a  = id_valid && id_use_rs1 && ex_valid  && (ex_rd  == id_rs1);
    ex_b  = id_valid && id_use_rs2 && ex_valid  && (ex_rd  == id_rs2);
    mem_a = id_valid && id_use_rs1 && mem_valid && (mem_rd == id_rs1);
    mem_b = id_valid && id_use_rs2 && mem_valid && (mem_rd == id_rs2);
`ifdef HAZARD_FWD_EN
    hazard = ex_load && (ex_a || ex_b);
    // Youngest producer wins: EX entry will sit in MEM when consumer is in EX
    if (ex_a) begin
      sel_a = 2'b01;
    end else if (mem_a) begin
      sel_a = 2'b10;
    end else begin
      sel_a = 2'b00;
    end
    if (ex_b) begin
      sel_b = 2'b01;
    end else if (mem_b) begin
      sel_b = 2'b10;
    end else begin
      sel_b = 2'b00;
    end
`else
    hazard = ex_a || ex_b || mem_a || mem_b;
    sel_a  = 2'b00;
    sel_b  = 2'b00;
`endif
    // Freeze beats redirect, redirect beats hazard stall
    redirect    = !mem_busy && (state == RUN) && ex_redirect;
    in_flush    = !mem_busy && (state == FLUSH);
    stall_pc    = !mem_busy && (state == RUN) && !ex_redirect && hazard;
    stall_ifid  = stall_pc;
    bubble_idex = redirect || stall_pc;
    flush_ifid  = redirect || in_flush;
    freeze      = mem_busy;
    kill        = bubble_idex || flush_ifid;
  end

  // Advance tracking table, latch forward selects and step the flush FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ex_valid  <= 1'b0;
      ex_rd     <= 5'd0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= 5'd0;
      mem_load  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_load   <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (!mem_busy) begin
      ex_valid  <= id_valid && id_regwrite && (id_rd != 5'd0) && !kill;
      ex_rd     <= id_rd;
      ex_load   <= id_memread;
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_load  <= ex_load;
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_load   <= mem_load;
      fwd_a_sel <= kill ? 2'b00 : sel_a;
      fwd_b_sel <= kill ? 2'b00 : sel_b;
      case (state)
        RUN:     state <= ex_redirect ? FLUSH : RUN;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
